// File: rtl/sun_pll_ctrl.sv
// Ring-oscillator PLL power-up sequencer and lock detector.
// The lock detector compares feedback edges against reference edges over repeated windows.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_OFF     | PLL powered down, waiting for en
// S_SETTLE  | PLL powered, waiting SETTLE_CYC cycles before measuring
// S_MEASURE | counting windows until LOCK_WINS good in a row, or timeout
// S_LOCKED  | lock reported; windows keep running, a bad one drops lock
// S_FAIL    | lock timeout; PLL powered down until en is seen low
module sun_pll_ctrl #(
    parameter int SETTLE_CYC   = 1024,
    parameter int WIN_REF      = 64,
    parameter int TOL          = 2,
    parameter int LOCK_WINS    = 4,
    parameter int TIMEOUT_WINS = 64,
    parameter int CW           = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          ck_ref_s,
    input  logic          ck_fb_s,
    output logic          pwrup_1v8,
    output logic          locked,
    output logic          fail,
    output logic          loss,
    output logic          busy,
    output logic [CW-1:0] fb_count
);

    localparam int SW      = $clog2(SETTLE_CYC + 1);
    localparam int GW      = $clog2(LOCK_WINS + 1);
    localparam int TW      = $clog2(TIMEOUT_WINS + 1);
    localparam int GOOD_LO = (WIN_REF > TOL) ? WIN_REF - TOL : 0;
    localparam int GOOD_HI = WIN_REF + TOL;

    typedef enum logic [2:0] {
        S_OFF,
        S_SETTLE,
        S_MEASURE,
        S_LOCKED,
        S_FAIL
    } state_t;

    state_t          state;
    logic [SW-1:0]   settle_cnt;
    logic [CW-1:0]   ref_cnt;
    logic [CW-1:0]   fb_cnt;
    logic [GW-1:0]   good_cnt;
    logic [TW-1:0]   win_cnt;
    logic            ref_prev;
    logic            fb_prev;

    logic            rise_ref;
    logic            rise_fb;
    logic [CW-1:0]   fb_next;
    logic            win_close;
    logic            win_good;
    logic [GW-1:0]   good_next;
    logic [TW-1:0]   win_next;

    assign rise_ref = ck_ref_s & ~ref_prev;
    assign rise_fb  = ck_fb_s & ~fb_prev;

    // fb_next already includes an fb rise on the closing cycle, so that edge lands in the closing window
    always_comb begin
        fb_next = fb_cnt;
        if (rise_fb && (fb_cnt != {CW{1'b1}}))
            fb_next = fb_cnt + 1'b1;
    end

    assign win_close = rise_ref && (ref_cnt == CW'(WIN_REF - 1));
    assign win_good  = (fb_next >= CW'(GOOD_LO)) && (fb_next <= CW'(GOOD_HI));
    assign good_next = win_good ? good_cnt + 1'b1 : '0;
    assign win_next  = win_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_OFF;
            settle_cnt <= '0;
            ref_cnt    <= '0;
            fb_cnt     <= '0;
            good_cnt   <= '0;
            win_cnt    <= '0;
            ref_prev   <= 1'b0;
            fb_prev    <= 1'b0;
            pwrup_1v8  <= 1'b0;
            locked     <= 1'b0;
            fail       <= 1'b0;
            loss       <= 1'b0;
            busy       <= 1'b0;
            fb_count   <= '0;
        end else begin
            ref_prev <= ck_ref_s;
            fb_prev  <= ck_fb_s;
            loss     <= 1'b0;
            if (!en) begin
                state      <= S_OFF;
                settle_cnt <= '0;
                ref_cnt    <= '0;
                fb_cnt     <= '0;
                good_cnt   <= '0;
                win_cnt    <= '0;
                pwrup_1v8  <= 1'b0;
                locked     <= 1'b0;
                fail       <= 1'b0;
                busy       <= 1'b0;
                fb_count   <= '0;
            end else begin
                case (state)
                    S_OFF: begin
                        state      <= S_SETTLE;
                        settle_cnt <= SW'(SETTLE_CYC - 1);
                        pwrup_1v8  <= 1'b1;
                        busy       <= 1'b1;
                    end
                    S_SETTLE: begin
                        if (settle_cnt == '0) begin
                            state    <= S_MEASURE;
                            ref_cnt  <= '0;
                            fb_cnt   <= '0;
                            good_cnt <= '0;
                            win_cnt  <= '0;
                        end else begin
                            settle_cnt <= settle_cnt - 1'b1;
                        end
                    end
                    S_MEASURE, S_LOCKED: begin
                        if (win_close) begin
                            ref_cnt  <= '0;
                            fb_cnt   <= '0;
                            fb_count <= fb_next;
                            if (state == S_MEASURE) begin
                                good_cnt <= good_next;
                                win_cnt  <= win_next;
                                // lock wins when it coincides with the timeout window
                                if (good_next == GW'(LOCK_WINS)) begin
                                    state  <= S_LOCKED;
                                    locked <= 1'b1;
                                    busy   <= 1'b0;
                                end else if (win_next == TW'(TIMEOUT_WINS)) begin
                                    state     <= S_FAIL;
                                    fail      <= 1'b1;
                                    pwrup_1v8 <= 1'b0;
                                    busy      <= 1'b0;
                                end
                            end else if (!win_good) begin
                                state    <= S_MEASURE;
                                locked   <= 1'b0;
                                loss     <= 1'b1;
                                busy     <= 1'b1;
                                good_cnt <= '0;
                                win_cnt  <= '0;
                            end
                        end else begin
                            ref_cnt <= ref_cnt + CW'(rise_ref);
                            fb_cnt  <= fb_next;
                        end
                    end
                    S_FAIL: begin
                        state <= S_FAIL;
                    end
                    default: begin
                        state <= S_OFF;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sun_pll_ctrl.sv
// Bench for sun_pll_ctrl: an edge-counting window model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sun_pll_ctrl;

    localparam int SETTLE_CYC   = 1024;
    localparam int WIN_REF      = 64;
    localparam int TOL          = 2;
    localparam int LOCK_WINS    = 4;
    localparam int TIMEOUT_WINS = 64;
    localparam int CW           = 8;
    localparam int SAT          = 255;

    logic          clk;
    logic          rst;
    logic          en;
    logic          ck_ref_s;
    logic          ck_fb_s;
    logic          pwrup_1v8;
    logic          locked;
    logic          fail;
    logic          loss;
    logic          busy;
    logic [CW-1:0] fb_count;

    int n_cmp = 0;
    int n_bad = 0;

    sun_pll_ctrl #(
        .SETTLE_CYC(SETTLE_CYC), .WIN_REF(WIN_REF), .TOL(TOL),
        .LOCK_WINS(LOCK_WINS), .TIMEOUT_WINS(TIMEOUT_WINS), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .ck_ref_s(ck_ref_s), .ck_fb_s(ck_fb_s),
        .pwrup_1v8(pwrup_1v8), .locked(locked), .fail(fail), .loss(loss),
        .busy(busy), .fb_count(fb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock-level generator: per ref period one fb pulse aligned with the ref rise
    // (dropped in the first `omit` of every 64 periods) and one mid-period extra
    // pulse in the first `extra` of every 64 periods; `fast` toggles fb every cycle.
    int ref_per = 16;
    int extra   = 0;
    int omit    = 0;
    bit fast    = 1'b0;
    int ph      = 0;
    int pidx    = 0;

    initial begin
        ck_ref_s = 1'b0;
        ck_fb_s  = 1'b0;
        forever begin
            int q;
            int h;
            @(posedge clk);
            #1;
            ph = ph + 1;
            if (ph >= ref_per) begin
                ph   = 0;
                pidx = pidx + 1;
            end
            q = pidx % 64;
            h = ref_per / 2;
            ck_ref_s = (ph < h);
            if (fast)
                ck_fb_s = ~ck_fb_s;
            else
                ck_fb_s = ((ph < 2) && (q >= omit)) || ((ph >= h) && (ph < h + 2) && (q < extra));
        end
    end

    // Behavioural model: phases, elapsed settle time and per-window edge tallies
    typedef enum int {M_OFF, M_SETTLE, M_MEAS, M_LOCK, M_FAIL} mphase_t;
    mphase_t mp = M_OFF;
    int  m_settle = 0, m_ref = 0, m_fb = 0, m_streak = 0, m_wins = 0;
    bit  m_prev_ref = 0, m_prev_fb = 0, m_close = 0;
    bit  e_pw = 0, e_lk = 0, e_fl = 0, e_ls = 0, e_bz = 0;
    int  e_fc = 0;

    task automatic model_step();
        bit rr, fr, good;
        int dev;
        rr = ck_ref_s && !m_prev_ref;
        fr = ck_fb_s && !m_prev_fb;
        m_close = 1'b0;
        e_ls = 1'b0;
        if (rst) begin
            mp = M_OFF;
            m_prev_ref = 0; m_prev_fb = 0;
            m_settle = 0; m_ref = 0; m_fb = 0; m_streak = 0; m_wins = 0;
            e_pw = 0; e_lk = 0; e_fl = 0; e_bz = 0; e_fc = 0;
        end else begin
            m_prev_ref = ck_ref_s;
            m_prev_fb  = ck_fb_s;
            if (!en) begin
                mp = M_OFF;
                m_settle = 0; m_ref = 0; m_fb = 0; m_streak = 0; m_wins = 0;
                e_pw = 0; e_lk = 0; e_fl = 0; e_bz = 0; e_fc = 0;
            end else begin
                case (mp)
                    M_OFF: begin
                        mp = M_SETTLE; m_settle = 0; e_pw = 1; e_bz = 1;
                    end
                    M_SETTLE: begin
                        m_settle++;
                        if (m_settle == SETTLE_CYC) begin
                            mp = M_MEAS; m_ref = 0; m_fb = 0; m_streak = 0; m_wins = 0;
                        end
                    end
                    M_MEAS, M_LOCK: begin
                        if (fr && m_fb < SAT) m_fb++;
                        if (rr) m_ref++;
                        if (m_ref == WIN_REF) begin
                            m_close = 1'b1;
                            e_fc = m_fb;
                            dev = (m_fb > WIN_REF) ? m_fb - WIN_REF : WIN_REF - m_fb;
                            good = (dev <= TOL);
                            m_ref = 0; m_fb = 0;
                            if (mp == M_MEAS) begin
                                m_streak = good ? m_streak + 1 : 0;
                                m_wins++;
                                if (m_streak == LOCK_WINS) begin
                                    mp = M_LOCK; e_lk = 1; e_bz = 0;
                                end else if (m_wins == TIMEOUT_WINS) begin
                                    mp = M_FAIL; e_fl = 1; e_pw = 0; e_bz = 0;
                                end
                            end else if (!good) begin
                                mp = M_MEAS; e_lk = 0; e_ls = 1; e_bz = 1;
                                m_streak = 0; m_wins = 0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    // Compare process: model advances on each rising edge, outputs checked on the falling edge
    initial begin
        int cyc = 0;
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            cyc++;
            n_cmp++;
            if ({pwrup_1v8, locked, fail, loss, busy} !== {e_pw, e_lk, e_fl, e_ls, e_bz} ||
                fb_count !== CW'(e_fc)) begin
                n_bad++;
                $display("FAIL cycle_%0d outputs: got pw=%b lk=%b fl=%b ls=%b bz=%b fc=%0d want pw=%b lk=%b fl=%b ls=%b bz=%b fc=%0d",
                         cyc, pwrup_1v8, locked, fail, loss, busy, fb_count,
                         e_pw, e_lk, e_fl, e_ls, e_bz, e_fc);
                if (n_bad >= 100) begin
                    summary();
                    $finish;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic bit probe(input int which);
        case (which)
            0:       return locked === 1'b1;
            1:       return fail === 1'b1;
            2:       return loss === 1'b1;
            default: return m_close;
        endcase
    endfunction

    task automatic wait_for(input string name, input int which, input int max_cyc, output int cyc);
        cyc = 0;
        while (cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (probe(which)) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s: not seen within %0d cycles", name, max_cyc);
    endtask

    initial begin
        int c;
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_pwrup", pwrup_1v8, 0);
        chk("reset_busy", busy, 0);
        chk("reset_fb_count", fb_count, 0);
        rst = 1'b0;
        @(negedge clk);

        // Matched clocks, period 16: lock after settle plus four windows
        en = 1'b1;
        @(negedge clk);
        chk("pwrup_after_en", pwrup_1v8, 1);
        chk("busy_in_settle", busy, 1);
        wait_for("lock_matched", 0, 7000, c);
        chk_range("lock_time_matched", c + 1, 5104, 5124);
        chk("fb_count_matched", fb_count, 64);
        chk("busy_when_locked", busy, 0);
        wait_for("close_after_lock", 3, 1100, c);
        chk("fb_count_next_window", fb_count, 64);
        chk("still_locked", locked, 1);

        // Loss: 50 fb edges per window, then restore and relock
        omit = 14;
        wait_for("loss_pulse", 2, 1100, c);
        chk("fb_count_at_loss", fb_count, 50);
        chk("locked_dropped", locked, 0);
        chk("busy_after_loss", busy, 1);
        omit = 0;
        @(negedge clk);
        chk("loss_one_cycle", loss, 0);
        wait_for("relock", 0, 4200, c);
        chk("relock_time", c + 1, 4096);

        // Saturation: fb toggles every cycle, eight times the ref rate
        en = 1'b0;
        @(negedge clk);
        chk("en_drop_locked", locked, 0);
        chk("en_drop_pwrup", pwrup_1v8, 0);
        fast = 1'b1;
        en = 1'b1;
        wait_for("sat_close1", 3, 2200, c);
        chk("fb_count_sat1", fb_count, 255);
        wait_for("sat_close2", 3, 1100, c);
        chk("fb_count_sat2", fb_count, 255);
        chk("sat_not_locked", locked, 0);
        en = 1'b0;
        @(negedge clk);
        chk("en_drop_meas_busy", busy, 0);
        chk("en_drop_meas_loss", loss, 0);
        chk("en_drop_meas_fb_count", fb_count, 0);
        fast = 1'b0;

        // Tolerance edges with period 8: 66 locks, 67 times out
        ref_per = 8;
        extra = 2;
        @(negedge clk);
        en = 1'b1;
        wait_for("lock_66", 0, 4300, c);
        chk("fb_count_66", fb_count, 66);
        en = 1'b0;
        extra = 3;
        @(negedge clk);
        en = 1'b1;
        wait_for("fail_67", 1, 36000, c);
        chk("fail_pwrup", pwrup_1v8, 0);
        chk("fail_locked", locked, 0);
        chk("fb_count_67", fb_count, 67);
        repeat (40) @(negedge clk);
        chk("fail_held", fail, 1);
        en = 1'b0;
        @(negedge clk);
        chk("fail_cleared", fail, 0);
        chk("fail_no_loss", loss, 0);
        en = 1'b1;
        @(negedge clk);
        chk("restart_pwrup", pwrup_1v8, 1);
        chk("restart_busy", busy, 1);

        // Reset in mid-settle, then restart with en still high
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_pwrup", pwrup_1v8, 0);
        chk("rst_mid_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_pwrup", pwrup_1v8, 1);
        en = 1'b0;
        repeat (3) @(negedge clk);

        summary();
        $finish;
    end

endmodule
